// File: rtl/mem_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and constants for the data-memory write arbiter.
//             The FSM state type, the store-size encodings (funct3) and the
//             requester indices are defined here.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam int REQ_CORE   = 0;
    localparam int REQ_LOADER = 1;

endpackage
`default_nettype wire

// File: rtl/mem_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_write_arbiter_if
//  Purpose  : Bundles the two requester channels (core = 0, loader = 1) and
//             the data-memory write port of the arbiter.
//  Ports    : req_valid/req_addrN/req_wdataN/req_funct3_N  requester -> arb
//             req_ack/req_err                               arb -> requester
//             mem_we/mem_addr/mem_wdata/mem_be              arb -> memory
//  Modports : master (requesters + memory observer), slave (arbiter)
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_write_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]        req_valid;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [2:0]        req_funct3_0;
    logic [2:0]        req_funct3_1;
    logic [1:0]        req_ack;
    logic              req_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;

    modport master (
        output req_valid, req_addr0, req_addr1, req_wdata0, req_wdata1,
               req_funct3_0, req_funct3_1,
        input  req_ack, req_err, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  req_valid, req_addr0, req_addr1, req_wdata0, req_wdata1,
               req_funct3_0, req_funct3_1,
        output req_ack, req_err, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface
`default_nettype wire

// File: rtl/mem_write_arbiter_store_align.sv
`default_nettype none
// ============================================================================
//  Module   : store_align
//  Purpose  : Combinational store lane steering. Turns a byte offset, a store
//             size and right-justified data into byte enables, lane-replicated
//             write data and an alignment/encoding error flag.
//  Ports    : i_addr_lo[1:0]  byte offset within the word
//             i_funct3[2:0]   store size (SB/SH/SW)
//             i_wdata[31:0]   right-justified store data
//             o_be[3:0]       byte enables
//             o_lane_data     replicated write data
//             o_illegal       misaligned or unknown size
//  Revision : 1.0 - initial release
// ============================================================================
module store_align
    import mem_arb_pkg::*;
(
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic [2:0]  i_funct3,
    input  wire logic [31:0] i_wdata,
    output logic      [3:0]  o_be,
    output logic      [31:0] o_lane_data,
    output logic             o_illegal
);

    always_comb begin
        o_be        = 4'b0000;
        o_lane_data = 32'h0;
        o_illegal   = 1'b1;
        case (i_funct3)
            F3_SB: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_lane_data = {4{i_wdata[7:0]}};
                o_illegal   = 1'b0;
            end
            F3_SH: begin
                o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_lane_data = {2{i_wdata[15:0]}};
                o_illegal   = i_addr_lo[0];
            end
            F3_SW: begin
                o_be        = 4'b1111;
                o_lane_data = i_wdata;
                o_illegal   = (i_addr_lo != 2'b00);
            end
            default: begin
                o_illegal   = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_write_arbiter
//  Purpose  : Round-robin arbiter between the core store path (0) and the
//             program loader (1) for data-memory writes. A granted request is
//             aligned, issued as a single-cycle registered write pulse and then
//             acknowledged; misaligned requests are acknowledged with an error
//             and never reach memory.
//  Ports    : clk      system clock (posedge)
//             reset_n  synchronous active-low reset
//             bus      mem_write_arbiter_if.slave (requests, acks, memory port)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_write_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    mem_write_arbiter_if.slave bus
);

    state_t            r_state, w_nxt_state;
    logic              r_last_grant, w_nxt_last_grant;
    logic              r_grant, w_nxt_grant;
    logic              r_mem_we, w_nxt_mem_we;
    logic [ADDR_W-1:0] r_mem_addr, w_nxt_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, w_nxt_mem_wdata;
    logic [3:0]        r_mem_be, w_nxt_mem_be;
    logic [1:0]        r_ack, w_nxt_ack;
    logic              r_err, w_nxt_err;

    // Requester selection: a lone valid wins outright, a tie goes to the
    // requester that did not win last time.
    logic              w_sel;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [2:0]        w_funct3;

    always_comb begin
        case (bus.req_valid)
            2'b01:   w_sel = 1'b0;
            2'b10:   w_sel = 1'b1;
            2'b11:   w_sel = ~r_last_grant;
            default: w_sel = 1'b0;
        endcase
        w_addr   = w_sel ? bus.req_addr1    : bus.req_addr0;
        w_wdata  = w_sel ? bus.req_wdata1   : bus.req_wdata0;
        w_funct3 = w_sel ? bus.req_funct3_1 : bus.req_funct3_0;
    end

    logic [3:0]  w_be;
    logic [31:0] w_lane_data;
    logic        w_illegal;

    store_align u_store_align (
        .i_addr_lo   (w_addr[1:0]),
        .i_funct3    (w_funct3),
        .i_wdata     (w_wdata[31:0]),
        .o_be        (w_be),
        .o_lane_data (w_lane_data),
        .o_illegal   (w_illegal)
    );

    // Next-state and next-output logic. The memory port registers double as
    // the latched payload, so they hold non-zero values only while in WRITE.
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_last_grant = r_last_grant;
        w_nxt_grant      = r_grant;
        w_nxt_mem_we     = 1'b0;
        w_nxt_mem_addr   = '0;
        w_nxt_mem_wdata  = '0;
        w_nxt_mem_be     = 4'b0000;
        w_nxt_ack        = 2'b00;
        w_nxt_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (|bus.req_valid) begin
                    w_nxt_grant      = w_sel;
                    w_nxt_last_grant = w_sel;
                    if (w_illegal) begin
                        w_nxt_state      = ACK;
                        w_nxt_ack[w_sel] = 1'b1;
                        w_nxt_err        = 1'b1;
                    end else begin
                        w_nxt_state     = WRITE;
                        w_nxt_mem_we    = 1'b1;
                        w_nxt_mem_addr  = {w_addr[ADDR_W-1:2], 2'b00};
                        w_nxt_mem_wdata = w_lane_data;
                        w_nxt_mem_be    = w_be;
                    end
                end
            end
            WRITE: begin
                w_nxt_state        = ACK;
                w_nxt_ack[r_grant] = 1'b1;
            end
            ACK: begin
                w_nxt_state = IDLE;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= 4'b0000;
            r_ack        <= 2'b00;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_last_grant <= w_nxt_last_grant;
            r_grant      <= w_nxt_grant;
            r_mem_we     <= w_nxt_mem_we;
            r_mem_addr   <= w_nxt_mem_addr;
            r_mem_wdata  <= w_nxt_mem_wdata;
            r_mem_be     <= w_nxt_mem_be;
            r_ack        <= w_nxt_ack;
            r_err        <= w_nxt_err;
        end
    end

    assign bus.req_ack   = r_ack;
    assign bus.req_err   = r_err;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;

endmodule
`default_nettype wire

// File: tb/tb_mem_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_write_arbiter
//  Purpose  : Self-checking bench for mem_write_arbiter. A transaction-level
//             model predicts every output cycle; directed requests add
//             hand-computed expectations.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_write_arbiter;

    logic clk;
    logic reset_n;

    mem_write_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_write_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [1:0]  ack;
        logic        err;
    } out_t;

    out_t exp_q[$];
    out_t exp_now;
    out_t m_o;
    int   m_last;
    int   m_g;
    int   m_n;
    int   m_off;
    logic [31:0] m_a;
    logic [31:0] m_d;
    logic [2:0]  m_f;

    // Transaction model: a granted request yields a fixed schedule of output
    // cycles (write, ack, idle gap) or (ack+err, idle gap); while a schedule
    // is pending no new request is looked at.
    always @(posedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            m_last  = 1;
            exp_now = '0;
        end else if (exp_q.size() > 0) begin
            exp_now = exp_q.pop_front();
        end else if (bus.req_valid != 2'b00) begin
            if (bus.req_valid == 2'b11) m_g = 1 - m_last;
            else                        m_g = bus.req_valid[1] ? 1 : 0;
            m_last = m_g;
            m_a = (m_g == 1) ? bus.req_addr1    : bus.req_addr0;
            m_d = (m_g == 1) ? bus.req_wdata1   : bus.req_wdata0;
            m_f = (m_g == 1) ? bus.req_funct3_1 : bus.req_funct3_0;
            m_n = (m_f == 3'd0) ? 1 : (m_f == 3'd1) ? 2 : (m_f == 3'd2) ? 4 : 0;
            m_off = int'(m_a % 4);
            m_o = '0;
            if (m_n != 0 && (m_off % m_n) == 0) begin
                m_o.we   = 1'b1;
                m_o.addr = m_a - 32'(m_off);
                for (int k = 0; k < 4; k++) begin
                    m_o.be[k] = (k >= m_off) && (k < m_off + m_n);
                    m_o.data[8*k +: 8] = m_d[8*(k % m_n) +: 8];
                end
                exp_now = m_o;
                m_o = '0;
                m_o.ack[m_g] = 1'b1;
                exp_q.push_back(m_o);
                exp_q.push_back('0);
            end else begin
                m_o.ack[m_g] = 1'b1;
                m_o.err = 1'b1;
                exp_now = m_o;
                exp_q.push_back('0);
            end
        end else begin
            exp_now = '0;
        end
    end

    out_t act;
    always @(negedge clk) begin
        if (chk_en) begin
            act.we   = bus.mem_we;
            act.addr = bus.mem_addr;
            act.data = bus.mem_wdata;
            act.be   = bus.mem_be;
            act.ack  = bus.req_ack;
            act.err  = bus.req_err;
            total++;
            if (act !== exp_now) begin
                bad++;
                $display("FAIL model t=%0t got we=%b addr=%h data=%h be=%b ack=%b err=%b need we=%b addr=%h data=%h be=%b ack=%b err=%b",
                         $time, act.we, act.addr, act.data, act.be, act.ack, act.err,
                         exp_now.we, exp_now.addr, exp_now.data, exp_now.be, exp_now.ack, exp_now.err);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] need);
        total++;
        if (got !== need) begin
            bad++;
            $display("FAIL %s got=%h need=%h", name, got, need);
        end
    endtask

    // One request on channel idx; returns after the ack cycle with valid
    // dropped. Latency is counted in negedges from driving to ack.
    task automatic single(input int idx, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] f3,
                          input bit exp_err, input logic [31:0] exp_addr,
                          input logic [31:0] exp_data, input logic [3:0] exp_be);
        bit   we_seen = 0;
        bit   acked   = 0;
        int   lat     = 0;
        logic [31:0] c_addr = 0, c_data = 0;
        logic [3:0]  c_be = 0;
        logic        c_err = 0;
        @(negedge clk);
        if (idx == 0) begin
            bus.req_addr0 = addr; bus.req_wdata0 = data; bus.req_funct3_0 = f3;
        end else begin
            bus.req_addr1 = addr; bus.req_wdata1 = data; bus.req_funct3_1 = f3;
        end
        bus.req_valid[idx] = 1'b1;
        for (int c = 1; c <= 10 && !acked; c++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                we_seen = 1; c_addr = bus.mem_addr; c_data = bus.mem_wdata; c_be = bus.mem_be;
            end
            if (bus.req_ack[idx]) begin
                acked = 1; lat = c; c_err = bus.req_err;
            end
        end
        bus.req_valid[idx] = 1'b0;
        chk("acked", 32'(acked), 32'd1);
        chk("err", 32'(c_err), 32'(exp_err));
        chk("we_seen", 32'(we_seen), exp_err ? 32'd0 : 32'd1);
        chk("ack_latency", 32'(lat), exp_err ? 32'd1 : 32'd2);
        if (!exp_err) begin
            chk("mem_addr", c_addr, exp_addr);
            chk("mem_wdata", c_data, exp_data);
            chk("mem_be", 32'(c_be), 32'(exp_be));
        end
    endtask

    int acks[$];
    int ack_t[$];
    int cyc;
    bit seen;

    initial begin
        reset_n = 1'b0;
        bus.req_valid    = 2'b11;
        bus.req_addr0    = 32'h0000_2000; bus.req_wdata0 = 32'h1111_1111; bus.req_funct3_0 = 3'b010;
        bus.req_addr1    = 32'h0000_3000; bus.req_wdata1 = 32'h2222_2222; bus.req_funct3_1 = 3'b010;

        // reset held for three edges with both requesters valid
        @(posedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_we", 32'(bus.mem_we), 32'd0);
            chk("rst_ack", 32'(bus.req_ack), 32'd0);
            chk("rst_addr", bus.mem_addr, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.req_ack != 2'b00) begin
                seen = 1;
                chk("first_grant", 32'(bus.req_ack), 32'd1);
                bus.req_valid = 2'b00;
            end
        end
        chk("first_ack_seen", 32'(seen), 32'd1);
        bus.req_valid = 2'b00;

        single(0, 32'h0000_1004, 32'hDEAD_BEEF, 3'b010, 0, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111);
        single(0, 32'h0000_0103, 32'h0000_00AB, 3'b000, 0, 32'h0000_0100, 32'hABAB_ABAB, 4'b1000);
        single(0, 32'h0000_0102, 32'h0000_1234, 3'b001, 0, 32'h0000_0100, 32'h1234_1234, 4'b1100);
        single(0, 32'h0000_1002, 32'h5555_5555, 3'b010, 1, 32'h0, 32'h0, 4'b0000);
        single(1, 32'h0000_0201, 32'h0000_7777, 3'b001, 1, 32'h0, 32'h0, 4'b0000);
        single(1, 32'h0000_0200, 32'h0000_7777, 3'b011, 1, 32'h0, 32'h0, 4'b0000);
        single(1, 32'h0000_2001, 32'hFFFF_FF5A, 3'b000, 0, 32'h0000_2000, 32'h5A5A_5A5A, 4'b0010);

        // contention: last winner was the loader, so the core goes first
        @(negedge clk);
        bus.req_addr0 = 32'h0000_0010; bus.req_wdata0 = 32'hA0A0_A0A0; bus.req_funct3_0 = 3'b010;
        bus.req_addr1 = 32'h0000_0020; bus.req_wdata1 = 32'hB1B1_B1B1; bus.req_funct3_1 = 3'b010;
        bus.req_valid = 2'b11;
        cyc = 0;
        while (acks.size() < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.req_ack != 2'b00) begin
                acks.push_back(bus.req_ack[1] ? 1 : 0);
                ack_t.push_back(cyc);
            end
        end
        bus.req_valid = 2'b00;
        chk("contention_count", 32'(acks.size()), 32'd4);
        if (acks.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("contention_grant", 32'(acks[i]), 32'(i % 2));
            for (int i = 1; i < 4; i++) chk("contention_spacing", 32'(ack_t[i] - ack_t[i-1]), 32'd3);
        end

        // reset while the write pulse is up
        @(negedge clk);
        @(negedge clk);
        bus.req_addr0 = 32'h0000_0040; bus.req_wdata0 = 32'hCAFE_F00D; bus.req_funct3_0 = 3'b010;
        bus.req_valid = 2'b01;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.mem_we) seen = 1;
        end
        chk("abort_we_seen", 32'(seen), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_we_drop", 32'(bus.mem_we), 32'd0);
        chk("abort_no_ack", 32'(bus.req_ack), 32'd0);
        reset_n = 1'b1;
        bus.req_valid = 2'b00;
        single(0, 32'h0000_0040, 32'hCAFE_F00D, 3'b010, 0, 32'h0000_0040, 32'hCAFE_F00D, 4'b1111);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
